// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared PC-source and sequencer-state types
package otter_pkg;

    typedef enum logic [2:0] {
        PC_PLUS4  = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JAL    = 3'd3,
        PC_MTVEC  = 3'd4,
        PC_MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        SEQ_FETCH = 2'd0,
        SEQ_EXEC  = 2'd1,
        SEQ_ERR   = 2'd2
    } seq_state_t;

    localparam logic [31:0] INSN_BYTES = 32'd4;

endpackage

// File: rtl/pc_target_mux.sv
// rtl/pc_target_mux.sv - next-PC select, jalr bit0 clear, alignment handling (PC_MISALIGN_TRAP_EN)
module pc_target_mux
    import otter_pkg::*;
(
    input  logic [2:0]  pc_source,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] jalr,
    input  logic [31:0] branch,
    input  logic [31:0] jal,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] raw;

    // Pick the candidate; unused encodings 6-7 fall back to sequential flow.
    always_comb begin
        raw = pc_plus4;
        case (pc_source)
            PC_JALR:   raw = {jalr[31:1], 1'b0};
            PC_BRANCH: raw = branch;
            PC_JAL:    raw = jal;
            PC_MTVEC:  raw = mtvec;
            PC_MEPC:   raw = mepc;
            default:   raw = pc_plus4;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    // A misaligned target is redirected to the trap vector and flagged.
    always_comb begin
        misaligned = |raw[1:0];
        target     = misaligned ? mtvec : raw;
    end
`else
    // Without trapping, low bits are simply dropped so the PC stays word aligned.
    always_comb begin
        misaligned = 1'b0;
        target     = raw & ~32'd3;
    end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/exec PC sequencer with fetch timeout (PC_MISALIGN_TRAP_EN enables misalign trap)
module pc_sequencer
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_VEC     = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  pc_source,
    input  logic [31:0] jalr,
    input  logic [31:0] branch,
    input  logic [31:0] jal,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        advance,
    input  logic        stall,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        misalign,
    output logic        fetch_err,
    output logic [31:0] instret
);

    localparam int             TW       = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(FETCH_TIMEOUT - 1);

    seq_state_t    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic          ir_valid_q, ir_valid_d;
    logic          imem_req_q, imem_req_d;
    logic          misalign_q, misalign_d;
    logic          fetch_err_q, fetch_err_d;
    logic [31:0]   instret_q, instret_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [31:0]   target;
    logic          target_mis;

    assign pc_plus4 = pc_q + INSN_BYTES;

    pc_target_mux u_mux (
        .pc_source  (pc_source),
        .pc_plus4   (pc_plus4),
        .jalr       (jalr),
        .branch     (branch),
        .jal        (jal),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .target     (target),
        .misaligned (target_mis)
    );

    // Next-state and registered-output computation for the fetch/exec/error FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        imem_req_d  = imem_req_q;
        misalign_d  = 1'b0;
        fetch_err_d = fetch_err_q;
        instret_d   = instret_q;
        tmo_d       = tmo_q;
        case (state_q)
            SEQ_FETCH: begin
                imem_req_d = 1'b1;
                ir_valid_d = 1'b0;
                if (imem_ack) begin
                    ir_d       = imem_data;
                    ir_valid_d = 1'b1;
                    imem_req_d = 1'b0;
                    tmo_d      = '0;
                    state_d    = SEQ_EXEC;
                end else if (tmo_q == TMO_LAST) begin
                    imem_req_d  = 1'b0;
                    fetch_err_d = 1'b1;
                    state_d     = SEQ_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            SEQ_EXEC: begin
                if (advance && !stall) begin
                    pc_d       = target;
                    instret_d  = instret_q + 32'd1;
                    misalign_d = target_mis;
                    imem_req_d = 1'b1;
                    ir_valid_d = 1'b0;
                    tmo_d      = '0;
                    state_d    = SEQ_FETCH;
                end
            end
            default: begin
                imem_req_d = 1'b0;
                ir_valid_d = 1'b0;
                state_d    = SEQ_ERR;
            end
        endcase
    end

    // Single state register; reset abandons any in-flight fetch and drops the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEQ_FETCH;
            pc_q        <= RESET_VEC;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            imem_req_q  <= 1'b0;
            misalign_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            instret_q   <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            imem_req_q  <= imem_req_d;
            misalign_q  <= misalign_d;
            fetch_err_q <= fetch_err_d;
            instret_q   <= instret_d;
            tmo_q       <= tmo_d;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign imem_req  = imem_req_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign misalign  = misalign_q;
    assign fetch_err = fetch_err_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  pc_source;
    logic [31:0] jalr, branch, jal, mtvec, mepc;
    logic        advance, stall, imem_ack;
    logic [31:0] imem_data;
    logic [31:0] pc, pc_plus4, imem_addr, ir, instret;
    logic        imem_req, ir_valid, misalign, fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        logic        mis;
    } commit_t;

    commit_t     commit_q[$];
    logic [31:0] fetch_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic [31:0] m_ir;

    pc_sequencer #(.RESET_VEC(32'h0), .FETCH_TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_source (pc_source),
        .jalr      (jalr),
        .branch    (branch),
        .jal       (jal),
        .mtvec     (mtvec),
        .mepc      (mepc),
        .advance   (advance),
        .stall     (stall),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .misalign  (misalign),
        .fetch_err (fetch_err),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        advance = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_data = '0;
        pc_source = 3'd0; jalr = '0; branch = '0; jal = '0;
        commit_q.delete(); fetch_q.delete();
        m_pc = 32'h0; m_instret = 32'h0; m_ir = 32'h0;
        #1;
        chk("rst_req_immediate", imem_req, 1'b0);
        chk("rst_pc_immediate", pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_fetch_err", fetch_err, 1'b0);
        chk("rst_misalign", misalign, 1'b0);
        rst_n = 1'b1;
    endtask

    // Wait for a request, answer it, then expect the word latched as a valid IR.
    task automatic fetch(input logic [31:0] data);
        int n = 0;
        @(negedge clk);
        while (!imem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, m_pc);
        imem_ack = 1'b1;
        imem_data = data;
        fetch_q.push_back(data);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_data = 32'hDEAD_BEEF;
        m_ir = fetch_q.pop_front();
        chk("fetch_ir_valid", ir_valid, 1'b1);
        chk("fetch_ir", ir, m_ir);
        chk("fetch_req_drop", imem_req, 1'b0);
    endtask

    // Commit with the given source; expected PC is supplied by the caller.
    task automatic commit(input logic [2:0] src, input logic [31:0] t_jalr,
                          input logic [31:0] t_branch, input logic [31:0] t_jal,
                          input logic [31:0] exp_pc, input logic exp_mis);
        commit_t e;
        pc_source = src; jalr = t_jalr; branch = t_branch; jal = t_jal;
        stall = 1'b0;
        advance = 1'b1;
        commit_q.push_back('{pc: exp_pc, instret: m_instret + 32'd1, mis: exp_mis});
        m_instret = m_instret + 32'd1;
        m_pc = exp_pc;
        @(negedge clk);
        advance = 1'b0;
        e = commit_q.pop_front();
        chk("commit_req", imem_req, 1'b1);
        chk("commit_pc", pc, e.pc);
        chk("commit_addr", imem_addr, e.pc);
        chk("commit_pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("commit_instret", instret, e.instret);
        chk("commit_misalign", misalign, e.mis);
        chk("commit_ir_valid", ir_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_mis_b;
        logic [31:0] exp_pc_b;
        mtvec = 32'h80;
        mepc  = 32'h444;
        do_reset();

        fetch(32'h0000_0013);
        commit(3'd3, '0, '0, 32'h100, 32'h100, 1'b0);
        fetch(32'h0000_0093);
        commit(3'd3, '0, '0, 32'h200, 32'h200, 1'b0);
        fetch(32'h0011_0113);

        // Stall blocks advance for five cycles.
        stall = 1'b1;
        advance = 1'b1;
        pc_source = 3'd3; jal = 32'h999;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_pc", pc, m_pc);
            chk("stall_ir", ir, m_ir);
            chk("stall_instret", instret, m_instret);
            chk("stall_req", imem_req, 1'b0);
        end
        commit(3'd0, '0, '0, '0, 32'h204, 1'b0);
        fetch(32'h0000_1111);

`ifdef PC_MISALIGN_TRAP_EN
        exp_pc_b = 32'h80; exp_mis_b = 1'b1;
`else
        exp_pc_b = 32'h100; exp_mis_b = 1'b0;
`endif
        commit(3'd2, '0, 32'h102, '0, exp_pc_b, exp_mis_b);
        @(negedge clk);
        chk("misalign_pulse_end", misalign, 1'b0);
        fetch(32'h0000_2222);
        commit(3'd1, 32'h301, '0, '0, 32'h300, 1'b0);
        fetch(32'h0000_3333);
        commit(3'd6, '0, '0, '0, 32'h304, 1'b0);
        fetch(32'h0000_4444);
        commit(3'd4, '0, '0, '0, 32'h80, 1'b0);
        fetch(32'h0000_5555);
        commit(3'd5, '0, '0, '0, 32'h444, 1'b0);
        fetch(32'h0000_6666);
        commit(3'd3, '0, '0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        fetch(32'h0000_7777);
        commit(3'd0, '0, '0, '0, 32'h0, 1'b0);

        // Advance/stall have no effect while fetching.
        advance = 1'b1; stall = 1'b0; pc_source = 3'd3; jal = 32'h500;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fetch_ignore_pc", pc, m_pc);
            chk("fetch_ignore_instret", instret, m_instret);
        end
        advance = 1'b0;
        fetch(32'h0000_8888);
        commit(3'd0, '0, '0, '0, 32'h4, 1'b0);

        // Reset in the middle of a fetch, then the next ack belongs to RESET_VEC.
        do_reset();
        fetch(32'h0000_ABCD);
        chk("late_ack_instret", instret, 32'h0);

        // Fetch timeout.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) chk("tmo_not_yet", fetch_err, 1'b0);
            if (k == 16) begin
                chk("tmo_err", fetch_err, 1'b1);
                chk("tmo_req", imem_req, 1'b0);
                chk("tmo_ir_valid", ir_valid, 1'b0);
            end
        end
        imem_ack = 1'b1; imem_data = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("err_sticky", fetch_err, 1'b1);
        chk("err_ack_ignored", ir_valid, 1'b0);
        do_reset();
        @(negedge clk);
        chk("err_clear", fetch_err, 1'b0);
        chk("err_clear_pc", pc, 32'h0);
        chk("err_clear_req", imem_req, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_VEC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: FETCH_TIMEOUT, 16, maximum FETCH cycles without IMEM_ACK before FETCH_ERR.
REQ-003 CLK  in  1  single clock, all state on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 PC_SOURCE  in  3  next-PC select: 0 PC+4, 1 jalr, 2 branch, 3 jal, 4 MTVEC, 5 MEPC; 6-7 treated as 0.
REQ-006 JALR, BRANCH, JAL, MTVEC, MEPC  in  32 each  candidate targets from the branch-address generator and CSR file.
REQ-007 ADVANCE  in  1  current instruction complete; commit next PC.
REQ-008 STALL  in  1  hold current instruction; blocks ADVANCE.
REQ-009 IMEM_ACK  in  1  instruction memory returned IMEM_DATA this cycle.
REQ-010 IMEM_DATA  in  32  fetched instruction word.
REQ-011 PC  out  32  current PC; PC_PLUS4  out  32  PC+4.
REQ-012 IMEM_REQ  out  1  fetch request; IMEM_ADDR  out  32  equals PC.
REQ-013 IR  out  32  latched instruction; IR_VALID  out  1  high while IR holds the instruction at PC.
REQ-014 MISALIGN  out  1  one-cycle pulse on misaligned target; FETCH_ERR  out  1  sticky fetch-timeout flag.
REQ-015 INSTRET  out  32  count of committed instructions.

Function
REQ-016 FSM states: FETCH, EXEC, ERR; one state register.
REQ-017 FETCH: IMEM_REQ=1, IR_VALID=0; on IMEM_ACK latch IMEM_DATA into IR, go EXEC next edge.
REQ-018 FETCH timeout counter clears on FETCH entry; at FETCH_TIMEOUT cycles without ACK go ERR, set FETCH_ERR.
REQ-019 EXEC: IMEM_REQ=0, IR_VALID=1; ADVANCE=1 and STALL=0 -> PC<=selected target, INSTRET+1, go FETCH next edge.
REQ-020 EXEC with STALL=1: PC, IR, INSTRET held regardless of ADVANCE.
REQ-021 ADVANCE, STALL ignored outside EXEC; IMEM_ACK ignored outside FETCH.
REQ-022 ERR: IMEM_REQ=0, IR_VALID=0; left only by reset.
REQ-023 Commit latency: target sampled at ADVANCE edge, new PC visible and IMEM_REQ high on the following cycle.
REQ-024 PC+4 and INSTRET arithmetic 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0, INSTRET wraps to 0.
REQ-025 JALR target bit0 cleared before alignment check.

Reset
REQ-026 RST_N low asynchronously: state FETCH, PC=RESET_VEC, IR=0, IR_VALID=0, MISALIGN=0, FETCH_ERR=0, INSTRET=0, timeout counter=0.
REQ-027 IMEM_REQ SHALL be low while RST_N low; first request the cycle after deassertion.
REQ-028 Reset mid-fetch abandons the transaction; a late IMEM_ACK after reset is treated as ACK for RESET_VEC.

Configuration
REQ-029 Macro PC_MISALIGN_TRAP_EN defined: committed target with bits[1:0]!=0 -> PC<=MTVEC, MISALIGN pulses one cycle, INSTRET still increments.
REQ-030 Macro undefined: target bits[1:0] forced to 0, MISALIGN tied 0.

Structure
REQ-031 Shared package otter_pkg SHALL hold pc_src_t enum (PC_PLUS4, PC_JALR, PC_BRANCH, PC_JAL, PC_MTVEC, PC_MEPC) and seq_state_t enum.
REQ-032 One sub-module pc_target_mux: combinational select plus bit0 clear and alignment check; FSM, counters, registers in pc_sequencer.

Verification
REQ-033 Reset, RESET_VEC=0, ACK=1 cycle 2, IMEM_DATA=32'h0000_0013 -> IMEM_ADDR=0, IR=32'h13, IR_VALID=1 next cycle.
REQ-034 EXEC, PC=0x100, PC_SOURCE=3, JAL=0x200, ADVANCE=1 -> PC=0x200, IMEM_REQ=1 next cycle, INSTRET=1.
REQ-035 EXEC, STALL=1, ADVANCE=1 for 5 cycles -> PC, IR, INSTRET unchanged; release STALL -> commit in 1 cycle.
REQ-036 PC_MISALIGN_TRAP_EN set, PC_SOURCE=2, BRANCH=0x102, MTVEC=0x80 -> PC=0x80, MISALIGN one-cycle pulse; macro unset -> PC=0x100.
REQ-037 No ACK for 16 FETCH cycles -> FETCH_ERR=1, IMEM_REQ=0; RST_N pulse -> FETCH_ERR=0, PC=RESET_VEC.
REQ-038 PC=32'hFFFF_FFFC, PC_SOURCE=0, ADVANCE -> PC=0; RST_N low mid-FETCH -> IMEM_REQ low immediately, PC=RESET_VEC.
